// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 8-bit RISC pipeline.
//
// Holds the program counter, requests words from instruction ROM through a
// valid handshake and captures them into the IF/ID register that feeds the
// opcode decoder.  A one-entry skid buffer catches a word that arrives while
// the decoder is stalled, so no instruction is lost or duplicated.  Whenever
// no real instruction is available, IF/ID carries a NOP bubble.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   imem_req     out  fetch request to instruction ROM (registered)
//   imem_addr    out  fetch address, equal to the program counter
//   imem_rdata   in   returned instruction word
//   imem_valid   in   imem_rdata valid for imem_addr; sampled only while imem_req=1
//   stall        in   downstream cannot accept a new instruction
//   redirect     in   taken branch/jump: flush and reload the PC
//   redirect_pc  in   new PC when redirect=1
//   if_id_instr  out  registered instruction to decode
//   if_id_pc     out  PC of if_id_instr
//   if_id_valid  out  1 = real fetched instruction, 0 = bubble
//   opcode       out  top five bits of if_id_instr, straight from the register
// -----------------------------------------------------------------------------
module if_stage #(
    parameter int              ADDR_W     = 8,
    parameter int              INSTR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter logic [4:0]      NOP_OPCODE = 5'b00101
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid,
    output logic [4:0]         opcode
);

    localparam logic [INSTR_W-1:0] BUBBLE_WORD = {NOP_OPCODE, {(INSTR_W-5){1'b0}}};
    localparam logic [ADDR_W-1:0]  PC_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_req;
    logic [ADDR_W-1:0]    r_pc;
    logic [INSTR_W-1:0]   r_skid;
    logic [ADDR_W-1:0]    r_skid_pc;
    logic [INSTR_W-1:0]   r_if_id_instr;
    logic [ADDR_W-1:0]    r_if_id_pc;
    logic                 r_if_id_valid;
    logic                 w_resp;

    // A response only counts while the request is actually on the bus; this
    // also ignores imem_valid in the first cycle after reset, before the
    // registered request has risen.
    assign w_resp = r_req & imem_valid;

    // Fetch FSM, program counter, skid buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_req         <= 1'b0;
            r_pc          <= RESET_PC;
            r_skid        <= BUBBLE_WORD;
            r_skid_pc     <= {ADDR_W{1'b0}};
            r_if_id_instr <= BUBBLE_WORD;
            r_if_id_pc    <= {ADDR_W{1'b0}};
            r_if_id_valid <= 1'b0;
        end else if (redirect) begin
            // Flush wins over stall; any response in this cycle belongs to
            // the old path and is dropped together with the skid entry.
            r_state       <= ST_FETCH;
            r_req         <= 1'b1;
            r_pc          <= redirect_pc;
            r_skid        <= BUBBLE_WORD;
            r_skid_pc     <= {ADDR_W{1'b0}};
            r_if_id_instr <= BUBBLE_WORD;
            r_if_id_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_resp && !stall) begin
                        r_if_id_instr <= imem_rdata;
                        r_if_id_pc    <= r_pc;
                        r_if_id_valid <= 1'b1;
                        r_pc          <= r_pc + PC_ONE;
                        r_req         <= 1'b1;
                    end else if (w_resp && stall) begin
                        // Park the word; the PC still points at it so the
                        // HOLD release can advance exactly once.
                        r_skid    <= imem_rdata;
                        r_skid_pc <= r_pc;
                        r_state   <= ST_HOLD;
                        r_req     <= 1'b0;
                    end else if (!stall) begin
                        r_if_id_instr <= BUBBLE_WORD;
                        r_if_id_valid <= 1'b0;
                        r_req         <= 1'b1;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_if_id_instr <= r_skid;
                        r_if_id_pc    <= r_skid_pc;
                        r_if_id_valid <= 1'b1;
                        r_pc          <= r_pc + PC_ONE;
                        r_state       <= ST_FETCH;
                        r_req         <= 1'b1;
                    end else begin
                        r_req <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_FETCH;
                    r_req         <= 1'b1;
                    r_if_id_instr <= BUBBLE_WORD;
                    r_if_id_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_valid = r_if_id_valid;
    assign opcode      = r_if_id_instr[INSTR_W-1 -: 5];

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A behavioural reference tracks what the fetch stage must present after every
// clock edge; a compare process checks the DUT against it each cycle, and the
// directed sequence adds hand-computed literal expectations.  The ROM model
// returns rom_word(addr) for the address currently on the bus.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [15:0] BUBBLE = 16'h2800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic        if_id_valid;
    logic [4:0]  opcode;

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .opcode      (opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        return {a ^ 8'h3C, a};
    endfunction

    assign imem_rdata = rom_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: where fetch should be, whether a word is parked, and
    // the expected IF/ID contents.
    logic [7:0]  m_pc = 8'h00;
    logic        m_req = 1'b0;
    logic        m_hold = 1'b0;
    logic [15:0] m_hword = 16'h0000;
    logic [7:0]  m_hpc = 8'h00;
    logic        m_valid = 1'b0;
    logic [15:0] m_instr = BUBBLE;
    logic [7:0]  m_ipc = 8'h00;

    // Reference model update from the inputs seen at each edge.
    always @(posedge clk) begin : model
        logic [7:0]  n_pc, n_hpc, n_ipc;
        logic        n_req, n_hold, n_valid, resp;
        logic [15:0] n_hword, n_instr;
        n_pc = m_pc; n_req = m_req; n_hold = m_hold; n_hword = m_hword;
        n_hpc = m_hpc; n_valid = m_valid; n_instr = m_instr; n_ipc = m_ipc;
        if (rst) begin
            n_pc = 8'h00; n_req = 1'b0; n_hold = 1'b0;
            n_valid = 1'b0; n_instr = BUBBLE; n_ipc = 8'h00;
        end else if (redirect) begin
            n_pc = redirect_pc; n_req = 1'b1; n_hold = 1'b0;
            n_valid = 1'b0; n_instr = BUBBLE;
        end else if (m_hold) begin
            if (!stall) begin
                n_instr = m_hword; n_ipc = m_hpc; n_valid = 1'b1;
                n_pc = m_pc + 8'd1; n_hold = 1'b0; n_req = 1'b1;
            end
        end else begin
            resp = m_req && imem_valid;
            n_req = 1'b1;
            if (resp && !stall) begin
                n_instr = rom_word(m_pc); n_ipc = m_pc; n_valid = 1'b1;
                n_pc = m_pc + 8'd1;
            end else if (resp) begin
                n_hword = rom_word(m_pc); n_hpc = m_pc; n_hold = 1'b1; n_req = 1'b0;
            end else if (!stall) begin
                n_valid = 1'b0; n_instr = BUBBLE;
            end
        end
        m_pc <= n_pc; m_req <= n_req; m_hold <= n_hold; m_hword <= n_hword;
        m_hpc <= n_hpc; m_valid <= n_valid; m_instr <= n_instr; m_ipc <= n_ipc;
    end

    // Per-cycle comparison of every DUT output against the reference.
    always @(posedge clk) begin
        #1;
        chk("req", imem_req, m_req);
        chk("addr", imem_addr, m_pc);
        chk("valid", if_id_valid, m_valid);
        chk("instr", if_id_instr, m_instr);
        chk("opcode", opcode, m_instr[15:11]);
        if (m_valid) chk("pc", if_id_pc, m_ipc);
        if (if_id_valid === 1'b1) chk("instr_matches_rom", if_id_instr, rom_word(if_id_pc));
    end

    task automatic step(input logic r, input logic v, input logic s,
                        input logic d, input logic [7:0] rp);
        rst = r; imem_valid = v; stall = s; redirect = d; redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] pc);
        chk({tag, "_valid"}, if_id_valid, v);
        if (v) begin
            chk({tag, "_pc"}, if_id_pc, pc);
            chk({tag, "_instr"}, if_id_instr, rom_word(pc));
        end else begin
            chk({tag, "_bubble_op"}, opcode, 5'b00101);
        end
    endtask

    initial begin
        // Reset for two cycles with a zero-wait ROM.
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("rst0", 1'b0, 8'h00);
        chk("rst0_req", imem_req, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("rst1", 1'b0, 8'h00);
        chk("rst1_req", imem_req, 1'b0);
        chk("rst1_ifpc", if_id_pc, 8'h00);

        // First request rises after reset falls, then one word per cycle.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 8'h00);
        expect_out("first", 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            expect_out("stream", 1'b1, 8'(i));
        end

        // Wait states: valid every third cycle, two bubbles between words.
        for (int k = 0; k < 5; k++) begin
            step(1'b0, (k % 3) == 2, 1'b0, 1'b0, 8'h00);
            expect_out("wait", (k % 3) == 2, 8'h04);
        end
        chk("wait_addr", imem_addr, 8'h05);

        // Stall three cycles, arriving with a valid response at pc 5.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            chk("hold_req", imem_req, 1'b0);
            expect_out("hold", 1'b0, 8'h00);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("release", 1'b1, 8'h05);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("after_rel", 1'b1, 8'h06);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("after_rel2", 1'b1, 8'h07);

        // Stall without a response keeps IF/ID, pc unchanged.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        expect_out("stall_novalid", 1'b1, 8'h07);
        chk("stall_novalid_addr", imem_addr, 8'h08);

        // Redirect while HOLD has pc 9 parked: skid dropped.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("pre_skid", 1'b1, 8'h08);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        expect_out("skid9", 1'b1, 8'h08);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h40);
        expect_out("redir_hold", 1'b0, 8'h00);
        chk("redir_addr", imem_addr, 8'h40);
        chk("redir_req", imem_req, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("redir_first", 1'b1, 8'h40);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("redir_second", 1'b1, 8'h41);

        // Redirect to 0xFE with a response in the same cycle; PC wraps.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hFE);
        expect_out("wrap_redir", 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("wrap_fe", 1'b1, 8'hFE);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("wrap_ff", 1'b1, 8'hFF);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("wrap_00", 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("wrap_01", 1'b1, 8'h01);

        // Reset mid-fetch with a response pending: response ignored.
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("midrst", 1'b0, 8'h00);
        chk("midrst_addr", imem_addr, 8'h00);
        chk("midrst_req", imem_req, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("midrst_rel", 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("midrst_pc0", 1'b1, 8'h00);

        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 8-bit RISC pipeline, directly upstream of the opcode decoder.
- Holds the program counter and issues requests to instruction ROM through a valid handshake.
- Captures returned words into the IF/ID pipeline register and presents the 5-bit opcode field to the decoder.
- Handles downstream stall, branch/jump redirect (flush) and memory wait states. Inserts NOP bubbles whenever no valid instruction is available.

Parameters:
- ADDR_W, 8, program counter / ROM address width.
- INSTR_W, 16, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-5].
- RESET_PC, 0, PC value loaded on reset.
- NOP_OPCODE, 5'b00101, opcode used for bubbles; bubble word = {NOP_OPCODE, all-zero remainder}.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request to instruction ROM.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_rdata  in  INSTR_W  returned instruction word.
- imem_valid  in  1  imem_rdata valid for current imem_addr; only sampled while imem_req=1.
- stall  in  1  downstream cannot accept a new instruction; IF/ID must hold.
- redirect  in  1  taken branch/jump; flush and reload PC.
- redirect_pc  in  ADDR_W  new PC when redirect=1.
- if_id_instr  out  INSTR_W  registered instruction to decode.
- if_id_pc  out  ADDR_W  PC of if_id_instr.
- if_id_valid  out  1  if_id_instr is a real fetched instruction (0 = bubble).
- opcode  out  5  if_id_instr[INSTR_W-1:INSTR_W-5]; combinational from the register; feeds the decoder instruction input.

Behaviour:
- Reset, applied at a clock edge while rst=1:
  - pc=RESET_PC, state=FETCH.
  - if_id_instr=bubble word, if_id_pc=0, if_id_valid=0, skid buffer cleared.
  - imem_req=0 while rst=1. The first request issues the cycle after rst falls.
- Reset mid-operation overrides all other inputs; any outstanding response is discarded.
- States: FETCH and HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_valid=1 and stall=0: if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1, pc<=pc+1. Stay in FETCH.
  - imem_valid=1 and stall=1: skid<=imem_rdata, skid_pc<=pc. IF/ID unchanged. Go to HOLD.
  - imem_valid=0 and stall=0: IF/ID loads the bubble (if_id_valid<=0, if_id_instr<=bubble word). pc unchanged.
  - imem_valid=0 and stall=1: IF/ID holds. pc unchanged.
- HOLD:
  - imem_req=0, imem_valid ignored.
  - stall=1: everything holds.
  - stall=0: if_id_instr<=skid, if_id_pc<=skid_pc, if_id_valid<=1, pc<=pc+1. Go to FETCH.
- Redirect: highest priority after rst and overrides stall.
  - pc<=redirect_pc, if_id_valid<=0, if_id_instr<=bubble word, skid discarded, state<=FETCH.
  - A response arriving (imem_valid=1) in the redirect cycle is discarded.
  - The new address is presented the following cycle.
- PC arithmetic: pc+1 modulo 2^ADDR_W; 255 wraps to 0 with no flag.
- Latency: a zero-wait ROM (imem_valid=1 every request cycle) gives one instruction per cycle. A word appears on if_id_instr one clock after its imem_valid cycle.
- ROM contract: imem_addr may change while imem_req=1 (redirect). The ROM returns data only for the address currently presented.
- No instruction is ever lost or duplicated across stall/HOLD sequences.

Test Plan:
- Reset: hold rst 2 cycles, then release with zero-wait ROM returning word = addr -> if_id_valid=0 and bubble opcode 5'b00101 during reset; then if_id_pc 0,1,2,3 on consecutive cycles with if_id_instr matching.
- Wait states: ROM asserts imem_valid only every 3rd cycle -> two bubble cycles (if_id_valid=0, opcode=NOP_OPCODE) between each instruction; pc advances only on valid.
- Stall: stall=1 for 3 cycles arriving with a valid response at pc=5 -> HOLD entered, imem_req=0; on release if_id_pc=5 appears exactly once, followed by pc=6.
- Redirect during stall: in HOLD with skid pc=9, redirect=1 with redirect_pc=0x40 -> bubble next cycle, skid dropped, next valid if_id_pc=0x40; pc=9 never appears.
- Wrap: start redirect_pc=0xFE with zero-wait ROM -> if_id_pc sequence FE, FF, 00, 01.
- Reset mid-fetch: assert rst while imem_req=1 and imem_valid pending -> next cycle pc=RESET_PC, if_id_valid=0; the late response is ignored.
